// File: rtl/jtag_target_router_pkg.sv
// jtag_target_router_pkg: source-select encodings, parked pin levels and
// FSM state encoding shared by the JTAG target router and its guard timer.
// The `JTAG_* defines mirror the mode encodings for code that still uses
// the legacy macro names from the original top level.
`ifndef JTAG_TARGET_ROUTER_DEFS
`define JTAG_TARGET_ROUTER_DEFS
`define JTAG_INT  2'b00
`define JTAG_EXT  2'b01
`define JTAG_TEST 2'b10
`endif

package jtag_target_router_pkg;

  typedef enum logic [1:0] {
    MODE_INT  = `JTAG_INT,
    MODE_EXT  = `JTAG_EXT,
    MODE_TEST = `JTAG_TEST,
    MODE_BAD  = 2'b11
  } mode_t;

  typedef enum logic {
    ST_GUARD     = 1'b0,
    ST_CONNECTED = 1'b1
  } state_t;

  // Pin levels that keep a TAP idle and glitch-free while disconnected
  localparam logic PARK_TCK  = 1'b0;
  localparam logic PARK_TMS  = 1'b1;
  localparam logic PARK_TDI  = 1'b0;
  localparam logic PARK_TRST = 1'b1;

  function automatic logic mode_is_legal(input logic [1:0] m);
    return m != MODE_BAD;
  endfunction

endpackage

// File: rtl/jtag_guard_timer.sv
// jtag_guard_timer: loadable down-counter that saturates at zero and flags
// done while at zero. Kept generic so the TCK divider can reuse it.
module jtag_guard_timer #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  // Reset/load take priority; otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= RESET_VAL;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/jtag_target_router.sv
// jtag_target_router: routes the internal controller, the external header or
// the SPI test vector to one of NUM_TARGETS JTAG ports. Every change of
// source or target parks the pins for GUARD_CYCLES clocks so no TAP sees a
// TCK/TMS glitch. Data paths are combinational; only the selection is
// registered.
// Optional build macro: JTAG_SWITCH_TRST_EN -- when defined, the selected
// target's TRST is held low during the guard interval (TAP reset pulse).
module jtag_target_router
  import jtag_target_router_pkg::*;
#(
  parameter int NUM_TARGETS  = 2,
  parameter int GUARD_CYCLES = 16,
  parameter int SEL_W        = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             sel_mode,
  input  logic [SEL_W-1:0]       sel_target,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  output logic                   sel_err,
  output logic [1:0]             cur_mode,
  output logic [SEL_W-1:0]       cur_target,
  output logic                   switching,
  input  logic                   int_tms,
  input  logic                   int_tck,
  input  logic                   int_tdi,
  input  logic                   int_trst,
  output logic                   int_tdo,
  input  logic                   ext_tms,
  input  logic                   ext_tck,
  input  logic                   ext_tdi,
  input  logic                   ext_trst,
  output logic                   ext_tdo,
  input  logic [4:0]             test_out,
  output logic [4:0]             test_in,
  output logic [NUM_TARGETS-1:0] tgt_tms,
  output logic [NUM_TARGETS-1:0] tgt_tck,
  output logic [NUM_TARGETS-1:0] tgt_tdi,
  output logic [NUM_TARGETS-1:0] tgt_trst,
  input  logic [NUM_TARGETS-1:0] tgt_tdo
);

  localparam int              TW        = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [TW-1:0]   GUARD_VAL = TW'(GUARD_CYCLES - 1);

  state_t            state_reg;
  mode_t             cur_mode_reg;
  logic [SEL_W-1:0]  cur_target_reg;
  logic              sel_err_reg;

  logic timer_done;
  logic live;
  logic accept;
  logic req_legal;
  logic req_change;
  logic start_guard;

  // Reset blocks both acceptance and routing in the same cycle it is seen
  assign live      = (state_reg == ST_CONNECTED) && !rst;
  assign sel_ready = live;
  assign switching = !live;
  assign accept    = sel_valid && sel_ready;

  assign req_legal   = mode_is_legal(sel_mode) && (32'(sel_target) < 32'(NUM_TARGETS));
  assign req_change  = (sel_mode != cur_mode_reg) || (sel_target != cur_target_reg);
  assign start_guard = accept && req_legal && req_change;

  jtag_guard_timer #(
    .WIDTH     (TW),
    .RESET_VAL (GUARD_VAL)
  ) u_guard_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (start_guard),
    .load_val (GUARD_VAL),
    .done     (timer_done)
  );

  // Selection FSM: GUARD until the timer expires, then accept requests
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_GUARD;
      cur_mode_reg   <= MODE_INT;
      cur_target_reg <= '0;
      sel_err_reg    <= 1'b0;
    end else begin
      sel_err_reg <= accept && !req_legal;
      case (state_reg)
        ST_GUARD: begin
          if (timer_done) begin
            state_reg <= ST_CONNECTED;
          end
        end
        ST_CONNECTED: begin
          if (start_guard) begin
            cur_mode_reg   <= mode_t'(sel_mode);
            cur_target_reg <= sel_target;
            state_reg      <= ST_GUARD;
          end
        end
        default: state_reg <= ST_GUARD;
      endcase
    end
  end

  assign sel_err    = sel_err_reg;
  assign cur_mode   = cur_mode_reg;
  assign cur_target = cur_target_reg;

  logic src_tck, src_tms, src_tdi, src_trst;
  logic sel_tdo;

  // Pick the pin set of the active source
  always_comb begin
    src_tck  = int_tck;
    src_tms  = int_tms;
    src_tdi  = int_tdi;
    src_trst = int_trst;
    case (cur_mode_reg)
      MODE_EXT: begin
        src_tck  = ext_tck;
        src_tms  = ext_tms;
        src_tdi  = ext_tdi;
        src_trst = ext_trst;
      end
      MODE_TEST: begin
        src_tms  = test_out[0];
        src_tdi  = test_out[1];
        src_trst = test_out[2];
        src_tck  = test_out[3];
      end
      default: ;
    endcase
  end

  // TDO of the currently selected target
  always_comb begin
    sel_tdo = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (cur_target_reg == SEL_W'(i)) begin
        sel_tdo = tgt_tdo[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_tgt
      logic is_sel;
      logic drive;
      logic park_trst;
      assign is_sel = (cur_target_reg == SEL_W'(gi));
      assign drive  = is_sel && live;
`ifdef JTAG_SWITCH_TRST_EN
      assign park_trst = is_sel ? 1'b0 : PARK_TRST;
`else
      assign park_trst = PARK_TRST;
`endif
      assign tgt_tck[gi]  = drive ? src_tck  : PARK_TCK;
      assign tgt_tms[gi]  = drive ? src_tms  : PARK_TMS;
      assign tgt_tdi[gi]  = drive ? src_tdi  : PARK_TDI;
      assign tgt_trst[gi] = drive ? src_trst : park_trst;
    end
  endgenerate

  // Only the active source sees TDO, and nobody does during a guard interval
  assign int_tdo = live && (cur_mode_reg == MODE_INT) && sel_tdo;
  assign ext_tdo = live && (((cur_mode_reg == MODE_EXT) && sel_tdo) ||
                            ((cur_mode_reg == MODE_TEST) && test_out[4]));
  assign test_in = {sel_tdo, ext_tck, ext_trst, ext_tdi, ext_tms};

endmodule

// File: tb/tb_jtag_target_router.sv
// tb_jtag_target_router: random requests, resets and pin activity checked
// every cycle against a park-countdown reference model of the router.
module tb_jtag_target_router;

  localparam int NT = 2;
  localparam int SW = 2;
  localparam int GC = 16;
`ifdef JTAG_SWITCH_TRST_EN
  localparam bit TRST_EN = 1'b1;
`else
  localparam bit TRST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    sel_mode;
  logic [SW-1:0] sel_target;
  logic          sel_valid;
  logic          sel_ready, sel_err, switching;
  logic [1:0]    cur_mode;
  logic [SW-1:0] cur_target;
  logic          int_tms, int_tck, int_tdi, int_trst, int_tdo;
  logic          ext_tms, ext_tck, ext_tdi, ext_trst, ext_tdo;
  logic [4:0]    test_out, test_in;
  logic [NT-1:0] tgt_tms, tgt_tck, tgt_tdi, tgt_trst, tgt_tdo;

  jtag_target_router #(
    .NUM_TARGETS  (NT),
    .GUARD_CYCLES (GC),
    .SEL_W        (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_mode   (sel_mode),
    .sel_target (sel_target),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_err    (sel_err),
    .cur_mode   (cur_mode),
    .cur_target (cur_target),
    .switching  (switching),
    .int_tms    (int_tms),
    .int_tck    (int_tck),
    .int_tdi    (int_tdi),
    .int_trst   (int_trst),
    .int_tdo    (int_tdo),
    .ext_tms    (ext_tms),
    .ext_tck    (ext_tck),
    .ext_tdi    (ext_tdi),
    .ext_trst   (ext_trst),
    .ext_tdo    (ext_tdo),
    .test_out   (test_out),
    .test_in    (test_in),
    .tgt_tms    (tgt_tms),
    .tgt_tck    (tgt_tck),
    .tgt_tdi    (tgt_tdi),
    .tgt_trst   (tgt_trst),
    .tgt_tdo    (tgt_tdo)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: active selection plus number of parked cycles left
  int m_mode, m_target, m_park, m_err;
  int rst_left;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs held before it
  task automatic model_step(output bit acc);
    acc = 1'b0;
    if (rst) begin
      m_mode = 0; m_target = 0; m_park = GC; m_err = 0;
    end else if (m_park > 0) begin
      m_park--;
      m_err = 0;
    end else begin
      m_err = 0;
      if (sel_valid) begin
        acc = 1'b1;
        if (sel_mode == 2'd3 || int'(sel_target) >= NT) begin
          m_err = 1;
        end else if (int'(sel_mode) != m_mode || int'(sel_target) != m_target) begin
          m_mode   = int'(sel_mode);
          m_target = int'(sel_target);
          m_park   = GC;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit live;
    bit s_tck, s_tms, s_tdi, s_trst, tdo_sel;
    logic [NT-1:0] e_tck, e_tms, e_tdi, e_trst;
    bit e_int_tdo, e_ext_tdo;
    live = (m_park == 0) && !rst;
    case (m_mode)
      0: begin s_tck = int_tck; s_tms = int_tms; s_tdi = int_tdi; s_trst = int_trst; end
      1: begin s_tck = ext_tck; s_tms = ext_tms; s_tdi = ext_tdi; s_trst = ext_trst; end
      default: begin s_tms = test_out[0]; s_tdi = test_out[1]; s_trst = test_out[2]; s_tck = test_out[3]; end
    endcase
    tdo_sel = tgt_tdo[m_target];
    for (int t = 0; t < NT; t++) begin
      if (t == m_target && live) begin
        e_tck[t] = s_tck; e_tms[t] = s_tms; e_tdi[t] = s_tdi; e_trst[t] = s_trst;
      end else begin
        e_tck[t] = 1'b0; e_tms[t] = 1'b1; e_tdi[t] = 1'b0;
        e_trst[t] = (TRST_EN && t == m_target) ? 1'b0 : 1'b1;
      end
    end
    e_int_tdo = live && m_mode == 0 && tdo_sel;
    e_ext_tdo = live && ((m_mode == 1 && tdo_sel) || (m_mode == 2 && test_out[4]));
    check_val("switching",  switching,  (m_park > 0) || rst);
    check_val("sel_ready",  sel_ready,  (m_park == 0) && !rst);
    check_val("sel_err",    sel_err,    m_err);
    check_val("cur_mode",   cur_mode,   m_mode);
    check_val("cur_target", cur_target, m_target);
    check_val("tgt_tck",    tgt_tck,    e_tck);
    check_val("tgt_tms",    tgt_tms,    e_tms);
    check_val("tgt_tdi",    tgt_tdi,    e_tdi);
    check_val("tgt_trst",   tgt_trst,   e_trst);
    check_val("int_tdo",    int_tdo,    e_int_tdo);
    check_val("ext_tdo",    ext_tdo,    e_ext_tdo);
    check_val("test_in",    test_in,    {tdo_sel, ext_tck, ext_trst, ext_tdi, ext_tms});
  endtask

  // New pin activity every cycle; requests held until accepted
  task automatic drive_inputs(input bit accepted);
    int r;
    {int_tms, int_tck, int_tdi, int_trst} = 4'($urandom);
    {ext_tms, ext_tck, ext_tdi, ext_trst} = 4'($urandom);
    test_out = 5'($urandom);
    tgt_tdo  = NT'($urandom);
    if (rst_left > 0) rst_left--;
    else if ($urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 3);
    rst = (rst_left > 0);
    if (!(sel_valid && !accepted)) begin
      sel_valid = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r < 3) begin
        sel_mode   = 2'(m_mode);
        sel_target = SW'(m_target);
      end else if (r < 5) begin
        sel_mode   = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        sel_target = (sel_mode == 2'd3) ? SW'($urandom) : SW'($urandom_range(NT, 3));
      end else begin
        sel_mode   = 2'($urandom_range(0, 2));
        sel_target = SW'($urandom_range(0, NT - 1));
      end
    end
  endtask

  initial begin
    bit acc;
    rst = 1'b1; rst_left = 3;
    sel_valid = 1'b0; sel_mode = 2'd0; sel_target = '0;
    {int_tms, int_tck, int_tdi, int_trst} = 4'b0;
    {ext_tms, ext_tck, ext_tdi, ext_trst} = 4'b0;
    test_out = 5'b0; tgt_tdo = '0;
    m_mode = 0; m_target = 0; m_park = GC; m_err = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step(acc);
      if (acc)
        $display("req mode=%0d target=%0d -> err=%0d now mode=%0d target=%0d park=%0d",
                 sel_mode, sel_target, m_err, m_mode, m_target, m_park);
      #1;
      drive_inputs(acc);
      @(negedge clk);
      check_outputs();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_target_router.md
Name: jtag_target_router

Overview:
- Parametrised successor to the 3-way JTAG source mux in the Lynsyn top level.
- Routes one of three JTAG sources (internal jtag_controller, external JTAG_IN header, SPI-driven test vector) to one of NUM_TARGETS JTAG output ports.
- Sequences every change of source or target through a registered guard interval, so targets never see TCK/TMS glitches.
- Sits between LynsynTop's jtag_controller/spi_controller and the pads.

Parameters:
- NUM_TARGETS, 2: number of JTAG output ports (1..8).
- GUARD_CYCLES, 16: clk cycles outputs are parked after a switch (>=1).
- SEL_W, $clog2(NUM_TARGETS) (min 1): width of target select.

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  synchronous active-high reset.
- sel_mode  in  2  requested source: `JTAG_INT, `JTAG_EXT or `JTAG_TEST.
- sel_target  in  SEL_W  requested target index.
- sel_valid  in  1  request valid.
- sel_ready  out  1  request can be accepted.
- sel_err  out  1  one-cycle pulse: accepted request was illegal.
- cur_mode  out  2  active source.
- cur_target  out  SEL_W  active target.
- switching  out  1  guard interval in progress.
- int_tms, int_tck, int_tdi, int_trst  in  1 each  internal controller.
- int_tdo  out  1  TDO to internal controller.
- ext_tms, ext_tck, ext_tdi, ext_trst  in  1 each  external header.
- ext_tdo  out  1  TDO to external header.
- test_out  in  5  {TDO_ext, TCK, TRST, TDI, TMS} test vector.
- test_in  out  5  live pin readback.
- tgt_tms, tgt_tck, tgt_tdi, tgt_trst  out  NUM_TARGETS each  per-target outputs.
- tgt_tdo  in  NUM_TARGETS  per-target TDO.

Behaviour:
- Parked value for a target: TCK=0, TMS=1, TDI=0, TRST=1. Non-selected targets are always parked. The selected target is parked while switching=1.
- A source that is not selected, or any source while switching=1, receives TDO=0.
- Routing is combinational from the registered cur_mode/cur_target/state. Data paths are unregistered, so TCK pass-through adds zero clk latency.
- INT mode: int_* drives tgt_*[cur_target]; int_tdo = tgt_tdo[cur_target].
- EXT mode: ext_* drives tgt_*[cur_target]; ext_tdo = tgt_tdo[cur_target].
- TEST mode: test_out[0..3] = TMS, TDI, TRST, TCK drive the selected target; ext_tdo = test_out[4].
- test_in = {tgt_tdo[cur_target], ext_tck, ext_trst, ext_tdi, ext_tms}. It is live in all modes and states.
- FSM states: GUARD, CONNECTED.
  - Reset puts the FSM in GUARD with cur_mode=`JTAG_INT, cur_target=0, guard counter=GUARD_CYCLES-1, sel_err=0.
  - During reset, switching=1 and sel_ready=0.
- GUARD: counter decrements each cycle. When the counter is 0, the next state is CONNECTED. Parked state lasts exactly GUARD_CYCLES cycles after the accept edge or reset release.
- CONNECTED: sel_ready=1. An accept is sel_valid & sel_ready at a rising edge. On accept:
  - Illegal request (sel_mode=2'b11, or sel_target>=NUM_TARGETS): no state change; sel_err=1 for the next cycle.
  - Same mode and target as current: accepted with no guard and no glitch.
  - Otherwise: cur_* updated on the accept edge, counter loaded with GUARD_CYCLES-1, state goes to GUARD.
- sel_valid while sel_ready=0 is held off. The requester keeps sel_valid and request fields stable until accepted.
- Reset mid-GUARD restarts the guard from the reset values. Reset always wins over a simultaneous accept.

Optional Feature:
- Macro JTAG_SWITCH_TRST_EN.
- Defined: during GUARD the selected target's TRST is driven 0 (TAP reset pulse of GUARD_CYCLES cycles); all other parked values are unchanged.
- Undefined: TRST is parked at 1 during GUARD.

Decomposition:
- Shared defines file holds: `JTAG_INT/`JTAG_EXT/`JTAG_TEST encodings, the parked-pin constants, and the state encodings.
- One sub-module, jtag_guard_timer: loadable down-counter with done flag, shared with the future TCK divider.

Test Plan:
- Reset release, GUARD_CYCLES=16: switching=1 for exactly 16 cycles, then sel_ready=1. tgt_tms[0]=1 and tgt_tck[0]=0 throughout; then tgt_tck[0] follows int_tck.
- In CONNECTED (INT, 0), request EXT/target 1: tgt_*[0] parked immediately; target 1 parked for 16 cycles, then ext_tck toggling appears on tgt_tck[1]; ext_tdo = tgt_tdo[1].
- Request (INT, 0) while already at (INT, 0): accepted in 1 cycle, switching stays 0, and tgt_tck[0] shows no parked gap.
- Illegal requests: sel_mode=2'b11, then sel_target=3 with NUM_TARGETS=2. Each gives a sel_err pulse of exactly 1 cycle; cur_* are unchanged.
- TEST mode with test_out=5'b10110: tgt_tms=0, tdi=1, trst=1, tck=0 on the selected target; ext_tdo=1. Drive ext_tms=1 with tgt_tdo=0 -> test_in[0]=1, test_in[4]=0.
- rst asserted at guard cycle 5: state returns to (INT, 0) and the guard restarts at 16. With JTAG_SWITCH_TRST_EN defined, tgt_trst[0]=0 for all 16 cycles.
